// File: rtl/svc_pix_pattern_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// svc_pix_pattern_gen
// Test-pattern pixel source. It emits pixels in raster order, with x/y, at up
// to one pixel per clock under valid/ready backpressure. Mode, colour and
// geometry are captured once per frame, so a frame never tears.
//
// Optional feature macro: SVC_PIX_PATTERN_GEN_SCROLL_EN
//   When defined, a horizontal offset advances by 1 on every frame_done.
//   The offset feeds the checker and gradient patterns, so they scroll.
//   When undefined, the offset is constant 0 and no register is built.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   enable               run request, sampled only at frame start
//   mode                 0 colour bars, 1 checker, 2 gradient, 3 solid
//   cfg_red/grn/blu      solid colour (mode 3)
//   h_visible/v_visible  active pixels per line / active lines per frame
//   m_pix_*              pixel stream out (valid/data/x/y), m_pix_ready in
//   frame_start          1-clk pulse when pixel (0,0) is loaded
//   frame_done           1-clk pulse after the last pixel of a frame handshakes
// ---------------------------------------------------------------------------
module svc_pix_pattern_gen #(
    parameter int unsigned H_WIDTH     = 12,
    parameter int unsigned V_WIDTH     = 12,
    parameter int unsigned COLOR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [COLOR_WIDTH-1:0] cfg_red,
    input  logic [COLOR_WIDTH-1:0] cfg_grn,
    input  logic [COLOR_WIDTH-1:0] cfg_blu,
    input  logic [H_WIDTH-1:0]     h_visible,
    input  logic [V_WIDTH-1:0]     v_visible,
    output logic                   m_pix_valid,
    output logic [COLOR_WIDTH-1:0] m_pix_red,
    output logic [COLOR_WIDTH-1:0] m_pix_grn,
    output logic [COLOR_WIDTH-1:0] m_pix_blu,
    output logic [H_WIDTH-1:0]     m_pix_x,
    output logic [V_WIDTH-1:0]     m_pix_y,
    input  logic                   m_pix_ready,
    output logic                   frame_start,
    output logic                   frame_done
);

    localparam int unsigned HW  = H_WIDTH;
    localparam int unsigned VW  = V_WIDTH;
    localparam int unsigned CW  = COLOR_WIDTH;
    localparam int unsigned RGB = 3 * COLOR_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;

    // Per-frame shadows of the live configuration
    logic [1:0]    r_mode;
    logic [CW-1:0] r_cfg_red;
    logic [CW-1:0] r_cfg_grn;
    logic [CW-1:0] r_cfg_blu;
    logic [HW-1:0] r_h_vis;
    logic [VW-1:0] r_v_vis;

    // Output register and the bar position of the pixel it holds
    logic          r_valid;
    logic [CW-1:0] r_red;
    logic [CW-1:0] r_grn;
    logic [CW-1:0] r_blu;
    logic [HW-1:0] r_x;
    logic [VW-1:0] r_y;
    logic [HW-1:0] r_bar_cnt;
    logic [2:0]    r_bar_idx;
    logic          r_frame_start;
    logic          r_frame_done;

    logic          w_geom_ok;
    logic          w_start_ok;
    logic          w_last_x;
    logic          w_last_y;
    logic          w_last_pix;
    logic          w_adv;
    logic          w_end_frame;
    logic          w_do_start;
    logic [HW-1:0] w_bw_m1;
    logic [HW-1:0] w_nx;
    logic [VW-1:0] w_ny;
    logic [HW-1:0] w_nbar_cnt;
    logic [2:0]    w_nbar_idx;
    logic [HW-1:0] w_offset;
    logic [HW-1:0] w_start_offset;
    logic [RGB-1:0] w_run_rgb;
    logic [RGB-1:0] w_start_rgb;

    // Colour of one pixel from the pattern rules; px is x shifted by the scroll offset
    function automatic logic [RGB-1:0] f_color(
        input logic [1:0]    md,
        input logic [CW-1:0] cr,
        input logic [CW-1:0] cg,
        input logic [CW-1:0] cb,
        input logic [2:0]    bi,
        input logic [HW-1:0] x,
        input logic [VW-1:0] y,
        input logic [HW-1:0] off
    );
        logic [HW-1:0] px;
        logic [CW-1:0] ones;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
        px   = HW'(x + off);
        ones = '1;
        r    = '0;
        g    = '0;
        b    = '0;
        case (md)
            2'd0: begin
                r = bi[1] ? '0 : ones;
                g = bi[2] ? '0 : ones;
                b = bi[0] ? '0 : ones;
            end
            2'd1: begin
                r = (px[4] ^ y[4]) ? ones : '0;
                g = r;
                b = r;
            end
            2'd2: begin
                r = px[CW-1:0];
                g = y[CW-1:0];
                b = '0;
            end
            default: begin
                r = cr;
                g = cg;
                b = cb;
            end
        endcase
        return {r, g, b};
    endfunction

    // Frame-start qualification on the live inputs
    always_comb begin
        w_geom_ok  = (h_visible >= HW'(8)) && (v_visible != '0);
        w_start_ok = enable && w_geom_ok;
    end

    // Raster position and handshake decode; valid is always high in RUN
    always_comb begin
        w_last_x    = (r_x == HW'(r_h_vis - HW'(1)));
        w_last_y    = (r_y == VW'(r_v_vis - VW'(1)));
        w_last_pix  = w_last_x && w_last_y;
        w_adv       = (r_state == ST_RUN) && (!r_valid || m_pix_ready);
        w_end_frame = w_adv && r_valid && w_last_pix;
        w_do_start  = ((r_state == ST_IDLE) || w_end_frame) && w_start_ok;
    end

    // Next pixel position and bar tracking; the bar index saturates at 7 (black)
    always_comb begin
        w_bw_m1    = HW'((r_h_vis >> 3) - HW'(1));
        w_nx       = HW'(r_x + HW'(1));
        w_ny       = r_y;
        w_nbar_cnt = r_bar_cnt;
        w_nbar_idx = r_bar_idx;
        if (w_last_x) begin
            w_nx       = '0;
            w_ny       = VW'(r_y + VW'(1));
            w_nbar_cnt = '0;
            w_nbar_idx = '0;
        end else if (r_bar_idx != 3'd7) begin
            if (r_bar_cnt == w_bw_m1) begin
                w_nbar_cnt = '0;
                w_nbar_idx = 3'(r_bar_idx + 3'd1);
            end else begin
                w_nbar_cnt = HW'(r_bar_cnt + HW'(1));
            end
        end
    end

`ifdef SVC_PIX_PATTERN_GEN_SCROLL_EN
    logic [HW-1:0] r_offset;

    // Scroll offset: one step per completed frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_offset <= '0;
        end else if (w_end_frame) begin
            r_offset <= HW'(r_offset + HW'(1));
        end
    end

    // A back-to-back frame start sees the offset it is about to get
    always_comb begin
        w_offset       = r_offset;
        w_start_offset = w_end_frame ? HW'(r_offset + HW'(1)) : r_offset;
    end
`else
    always_comb begin
        w_offset       = '0;
        w_start_offset = '0;
    end
`endif

    // Colour for the next raster pixel and for pixel (0,0) of a new frame
    always_comb begin
        w_run_rgb   = f_color(r_mode, r_cfg_red, r_cfg_grn, r_cfg_blu,
                              w_nbar_idx, w_nx, w_ny, w_offset);
        w_start_rgb = f_color(mode, cfg_red, cfg_grn, cfg_blu,
                              3'd0, '0, '0, w_start_offset);
    end

    // Control FSM, shadow capture and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= '0;
            r_cfg_red     <= '0;
            r_cfg_grn     <= '0;
            r_cfg_blu     <= '0;
            r_h_vis       <= '0;
            r_v_vis       <= '0;
            r_valid       <= 1'b0;
            r_red         <= '0;
            r_grn         <= '0;
            r_blu         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_bar_cnt     <= '0;
            r_bar_idx     <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_frame_done  <= w_end_frame;
            if (w_do_start) begin
                r_state                 <= ST_RUN;
                r_mode                  <= mode;
                r_cfg_red               <= cfg_red;
                r_cfg_grn               <= cfg_grn;
                r_cfg_blu               <= cfg_blu;
                r_h_vis                 <= h_visible;
                r_v_vis                 <= v_visible;
                r_valid                 <= 1'b1;
                {r_red, r_grn, r_blu}   <= w_start_rgb;
                r_x                     <= '0;
                r_y                     <= '0;
                r_bar_cnt               <= '0;
                r_bar_idx               <= '0;
                r_frame_start           <= 1'b1;
            end else if (w_end_frame) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
            end else if (w_adv) begin
                r_valid               <= 1'b1;
                {r_red, r_grn, r_blu} <= w_run_rgb;
                r_x                   <= w_nx;
                r_y                   <= w_ny;
                r_bar_cnt             <= w_nbar_cnt;
                r_bar_idx             <= w_nbar_idx;
            end
        end
    end

    assign m_pix_valid = r_valid;
    assign m_pix_red   = r_red;
    assign m_pix_grn   = r_grn;
    assign m_pix_blu   = r_blu;
    assign m_pix_x     = r_x;
    assign m_pix_y     = r_y;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_svc_pix_pattern_gen.sv
`timescale 1ns/1ps
// Self-checking bench for svc_pix_pattern_gen: a vector table of single
// pixels, randomized-backpressure frames checked against a reference model,
// and hand sequences for latency, mid-frame changes, idle geometry and reset.
module tb_svc_pix_pattern_gen;

    localparam int HW = 12;
    localparam int VW = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = '0;
    logic [CW-1:0] cfg_red = '0;
    logic [CW-1:0] cfg_grn = '0;
    logic [CW-1:0] cfg_blu = '0;
    logic [HW-1:0] h_visible = '0;
    logic [VW-1:0] v_visible = '0;
    logic          m_pix_valid;
    logic [CW-1:0] m_pix_red;
    logic [CW-1:0] m_pix_grn;
    logic [CW-1:0] m_pix_blu;
    logic [HW-1:0] m_pix_x;
    logic [VW-1:0] m_pix_y;
    logic          m_pix_ready = 1'b0;
    logic          frame_start;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int g_frames = 0;

    svc_pix_pattern_gen #(.H_WIDTH(HW), .V_WIDTH(VW), .COLOR_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .cfg_red(cfg_red), .cfg_grn(cfg_grn), .cfg_blu(cfg_blu),
        .h_visible(h_visible), .v_visible(v_visible),
        .m_pix_valid(m_pix_valid), .m_pix_red(m_pix_red), .m_pix_grn(m_pix_grn),
        .m_pix_blu(m_pix_blu), .m_pix_x(m_pix_x), .m_pix_y(m_pix_y),
        .m_pix_ready(m_pix_ready), .frame_start(frame_start), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         hv;
        int         vv;
        int         md;
        int         cr;
        int         cg;
        int         cb;
        int         x;
        int         y;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [11:0] dut_rgb();
        return {m_pix_red, m_pix_grn, m_pix_blu};
    endfunction

    // Reference colour from the pattern rules, using plain arithmetic
    function automatic logic [11:0] ref_rgb(input int md, input int cr, input int cg,
                                           input int cb, input int w, input int x,
                                           input int y, input int off);
        int bw;
        int bar;
        int px;
        logic [3:0] r;
        logic [3:0] g;
        px = (x + off) % 4096;
        case (md)
            0: begin
                bw  = w / 8;
                bar = x / bw;
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 12'hFFF;
                    1: return 12'hFF0;
                    2: return 12'h0FF;
                    3: return 12'h0F0;
                    4: return 12'hF0F;
                    5: return 12'hF00;
                    6: return 12'h00F;
                    default: return 12'h000;
                endcase
            end
            1: return (((px / 16) % 2) != ((y / 16) % 2)) ? 12'hFFF : 12'h000;
            2: begin
                r = 4'(px % 16);
                g = 4'(y % 16);
                return {r, g, 4'h0};
            end
            default: return {4'(cr), 4'(cg), 4'(cb)};
        endcase
    endfunction

    function automatic int cur_off();
`ifdef SVC_PIX_PATTERN_GEN_SCROLL_EN
        return g_frames;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        enable      = 1'b0;
        m_pix_ready = 1'b0;
        g_frames    = 0;
        step();
        step();
    endtask

    task automatic setup(input int hv, input int vv, input int md,
                         input int cr, input int cg, input int cb);
        h_visible = 12'(hv);
        v_visible = 12'(vv);
        mode      = 2'(md);
        cfg_red   = 4'(cr);
        cfg_grn   = 4'(cg);
        cfg_blu   = 4'(cb);
    endtask

    // Runs one frame whose (0,0) is already loaded; random ready; checks every cycle.
    // When the expected row reaches chg_y, the live inputs are changed to n_*.
    task automatic play_frame(input string tag, input int md, input int cr, input int cg,
                              input int cb, input int w, input int h, input int off,
                              input int chg_y, input int n_md, input int n_cr,
                              input int n_cg, input int n_cb, input int n_en);
        int ex;
        int ey;
        int hs;
        int cyc;
        int xfs;
        int xfd;
        bit chg_done;
        ex = 0; ey = 0; hs = 0; cyc = 0; xfs = 0; xfd = 0; chg_done = 1'b0;
        chk($sformatf("%s_frame_start", tag), 64'(frame_start), 64'(1));
        while (hs < w * h) begin
            if (cyc > w * h * 20) begin
                chk($sformatf("%s_timeout_handshakes", tag), 64'(hs), 64'(w * h));
                return;
            end
            chk($sformatf("%s_valid", tag), 64'(m_pix_valid), 64'(1));
            chk($sformatf("%s_xy", tag), 64'({m_pix_x, m_pix_y}), 64'({12'(ex), 12'(ey)}));
            chk($sformatf("%s_rgb(%0d,%0d)", tag, ex, ey), 64'(dut_rgb()),
                64'(ref_rgb(md, cr, cg, cb, w, ex, ey, off)));
            if (cyc > 0 && frame_start) xfs++;
            if (cyc > 0 && frame_done) xfd++;
            m_pix_ready = ($urandom_range(0, 99) < 50);
            if (m_pix_valid && m_pix_ready) begin
                hs++;
                ex++;
                if (ex == w) begin
                    ex = 0;
                    ey++;
                end
            end
            if (!chg_done && ey == chg_y) begin
                chg_done = 1'b1;
                mode     = 2'(n_md);
                cfg_red  = 4'(n_cr);
                cfg_grn  = 4'(n_cg);
                cfg_blu  = 4'(n_cb);
                enable   = (n_en != 0);
            end
            step();
            cyc++;
        end
        chk($sformatf("%s_frame_done", tag), 64'(frame_done), 64'(1));
        chk($sformatf("%s_extra_frame_start", tag), 64'(xfs), 64'(0));
        chk($sformatf("%s_early_frame_done", tag), 64'(xfd), 64'(0));
        g_frames++;
    endtask

    initial begin
        bit found;
        bit seen;

        vecs[0]  = '{"bar_x0",      640, 480, 0, 0, 0, 0,   0,  0, 12'hFFF};
        vecs[1]  = '{"bar_x79",     640, 480, 0, 0, 0, 0,  79,  0, 12'hFFF};
        vecs[2]  = '{"bar_x80",     640, 480, 0, 0, 0, 0,  80,  0, 12'hFF0};
        vecs[3]  = '{"bar_x300",    640, 480, 0, 0, 0, 0, 300,  0, 12'h0F0};
        vecs[4]  = '{"bar_x560",    640, 480, 0, 0, 0, 0, 560,  0, 12'h000};
        vecs[5]  = '{"bar_x639",    640, 480, 0, 0, 0, 0, 639,  0, 12'h000};
        vecs[6]  = '{"h100_x83",    100, 480, 0, 0, 0, 0,  83,  0, 12'h00F};
        vecs[7]  = '{"h100_x96",    100, 480, 0, 0, 0, 0,  96,  0, 12'h000};
        vecs[8]  = '{"h100_x99",    100, 480, 0, 0, 0, 0,  99,  0, 12'h000};
        vecs[9]  = '{"h8_x3",         8,   2, 0, 0, 0, 0,   3,  0, 12'h0F0};
        vecs[10] = '{"chk_0_0",     640, 480, 1, 0, 0, 0,   0,  0, 12'h000};
        vecs[11] = '{"chk_16_0",    640, 480, 1, 0, 0, 0,  16,  0, 12'hFFF};
        vecs[12] = '{"chk_16_16",   640, 480, 1, 0, 0, 0,  16, 16, 12'h000};
        vecs[13] = '{"chk_0_16",     64, 480, 1, 0, 0, 0,   0, 16, 12'hFFF};
        vecs[14] = '{"grad_5_3",    640, 480, 2, 0, 0, 0,   5,  3, 12'h530};
        vecs[15] = '{"grad_20_17",   32, 480, 2, 0, 0, 0,  20, 17, 12'h410};
        vecs[16] = '{"solid_10_2",  640, 480, 3, 1, 2, 3,  10,  2, 12'h123};

        // Reset state
        do_reset();
        chk("reset_outputs",
            64'({m_pix_valid, m_pix_x, m_pix_y, m_pix_red, m_pix_grn, m_pix_blu,
                 frame_start, frame_done}), 64'(0));

        // Start latency: (0,0) one clock after the IDLE->RUN edge
        setup(640, 480, 0, 0, 0, 0);
        enable      = 1'b1;
        m_pix_ready = 1'b1;
        rst_n       = 1'b1;
        chk("pre_edge_valid", 64'(m_pix_valid), 64'(0));
        step();
        chk("first_valid", 64'(m_pix_valid), 64'(1));
        chk("first_frame_start", 64'(frame_start), 64'(1));
        chk("first_xy", 64'({m_pix_x, m_pix_y}), 64'(0));
        chk("first_rgb", 64'(dut_rgb()), 64'(12'hFFF));
        step();
        chk("second_frame_start", 64'(frame_start), 64'(0));
        chk("second_x", 64'(m_pix_x), 64'(1));

        // Vector table: run ready=1 until the pixel of interest, compare colour
        foreach (vecs[i]) begin
            do_reset();
            setup(vecs[i].hv, vecs[i].vv, vecs[i].md, vecs[i].cr, vecs[i].cg, vecs[i].cb);
            enable      = 1'b1;
            m_pix_ready = 1'b1;
            rst_n       = 1'b1;
            found       = 1'b0;
            for (int c = 0; c < 20000 && !found; c++) begin
                step();
                if (m_pix_valid && int'(m_pix_x) == vecs[i].x && int'(m_pix_y) == vecs[i].y)
                    found = 1'b1;
            end
            chk($sformatf("%s_found", vecs[i].name), 64'(found), 64'(1));
            chk($sformatf("%s_rgb", vecs[i].name), 64'(dut_rgb()), 64'(vecs[i].exp_rgb));
        end

        // Random-ready frames with mid-frame changes that must wait for the next frame
        do_reset();
        setup(64, 40, 2, 0, 0, 0);
        enable = 1'b1;
        rst_n  = 1'b1;
        step();
        play_frame("f0_grad",  2, 0, 0, 0, 64, 40, cur_off(), 20, 1, 0, 0, 0, 1);
        play_frame("f1_chk",   1, 0, 0, 0, 64, 40, cur_off(), 20, 3, 10, 5, 12, 1);
        play_frame("f2_solid", 3, 10, 5, 12, 64, 40, cur_off(), 20, 0, 0, 0, 0, 0);
        chk("idle_after_disable_valid", 64'(m_pix_valid), 64'(0));
        step();
        chk("single_frame_done", 64'(frame_done), 64'(0));
        step();
        step();
        chk("idle_hold_valid", 64'(m_pix_valid), 64'(0));

        // Restart from IDLE: bars on a width that leaves a remainder
        setup(100, 6, 0, 0, 0, 0);
        enable = 1'b1;
        step();
        play_frame("f3_bars100", 0, 0, 0, 0, 100, 6, cur_off(), 3, 2, 0, 0, 0, 1);
        play_frame("f4_grad100", 2, 0, 0, 0, 100, 6, cur_off(), -1, 0, 0, 0, 0, 1);

        // Asynchronous reset mid-line, then a clean restart
        m_pix_ready = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({m_pix_valid, m_pix_x, m_pix_y, m_pix_red, m_pix_grn, m_pix_blu,
                 frame_start, frame_done}), 64'(0));
        step();
        g_frames = 0;
        setup(640, 480, 0, 0, 0, 0);
        enable = 1'b1;
        rst_n  = 1'b1;
        step();
        chk("restart_valid_fs", 64'({m_pix_valid, frame_start}), 64'(2'b11));
        chk("restart_xy", 64'({m_pix_x, m_pix_y}), 64'(0));

        // Illegal geometry never produces a valid pixel
        do_reset();
        setup(4, 10, 0, 0, 0, 0);
        enable      = 1'b1;
        m_pix_ready = 1'b1;
        rst_n       = 1'b1;
        seen        = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (m_pix_valid) seen = 1'b1;
        end
        chk("h4_never_valid", 64'(seen), 64'(0));
        setup(640, 0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (m_pix_valid) seen = 1'b1;
        end
        chk("v0_never_valid", 64'(seen), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
